// File: rtl/frame_tx.sv
// Frame transmitter: fetches FRAME_LEN bytes by index from a register bank and
// sends each as 8N1 serial data, LSB first, with an internal baud counter.
module frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FRAME_LEN    = 55,
  parameter int unsigned IDX_W        = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [7:0]       rd_data,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned       BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_TC  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_nxt;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_nxt;
  logic [7:0]        shift;
  logic [7:0]        shift_nxt;
  logic [IDX_W-1:0]  rd_idx_nxt;
  logic              tx_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              pend;
  logic              pend_nxt;
  logic              baud_tc;
  logic              accept;
  logic              last_byte;
  logic              last_bit;

  assign baud_tc   = (baud_cnt == BAUD_TC);
  assign accept    = start && !busy;
  assign last_byte = (rd_idx == LAST_IDX);
  assign last_bit  = (bit_cnt == 3'd7);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   if (baud_tc) state_nxt = DATA;
      DATA:    if (baud_tc && last_bit) state_nxt = STOP;
      STOP:    if (baud_tc) state_nxt = last_byte ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values; tx follows the current state one cycle
  // later, so completion is also reported one cycle after the stop-bit count
  // expires (pend) to line up with the end of the stop bit on the line.
  always_comb begin
    baud_nxt   = baud_cnt;
    bit_nxt    = bit_cnt;
    shift_nxt  = shift;
    rd_idx_nxt = rd_idx;
    tx_nxt     = 1'b1;
    busy_nxt   = busy;
    pend_nxt   = 1'b0;
    done_nxt   = pend;
    if (pend) begin
      busy_nxt = 1'b0;
    end
    case (state)
      IDLE: begin
        if (accept) begin
          rd_idx_nxt = '0;
          busy_nxt   = 1'b1;
        end
      end
      LOAD: begin
        shift_nxt = rd_data;
        baud_nxt  = '0;
      end
      START: begin
        tx_nxt = 1'b0;
        if (baud_tc) begin
          baud_nxt = '0;
          bit_nxt  = '0;
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        tx_nxt = shift[0];
        if (baud_tc) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift[7:1]};
          bit_nxt   = last_bit ? 3'd0 : bit_cnt + 3'd1;
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_tc) begin
          baud_nxt = '0;
          if (last_byte) begin
            pend_nxt   = 1'b1;
            rd_idx_nxt = '0;
          end else begin
            rd_idx_nxt = rd_idx + IDX_W'(1);
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        baud_nxt = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      rd_idx     <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pend       <= 1'b0;
    end else begin
      baud_cnt   <= baud_nxt;
      bit_cnt    <= bit_nxt;
      shift      <= shift_nxt;
      rd_idx     <= rd_idx_nxt;
      tx         <= tx_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
      pend       <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
// Directed bench for frame_tx with CLKS_PER_BIT=4, FRAME_LEN=3: checks the
// serial waveform, handshake outputs and index sequencing cycle by cycle.
module tb_frame_tx;

  localparam int unsigned CPB       = 4;
  localparam int unsigned FL        = 3;
  localparam int unsigned IW        = 2;
  localparam int unsigned BYTE_CYC  = 1 + 10 * CPB;
  localparam int unsigned FRAME_CYC = FL * BYTE_CYC + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [IW-1:0] rd_idx;
  logic [7:0]    rd_data;
  logic          tx;
  logic          busy;
  logic          frame_done;

  logic [7:0] bank      [FL];
  logic [7:0] ref_bytes [FL];
  int n_tests = 0;
  int n_fail  = 0;

  frame_tx #(
    .CLKS_PER_BIT(CPB),
    .FRAME_LEN   (FL),
    .IDX_W       (IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign rd_data = (rd_idx < IW'(FL)) ? bank[rd_idx] : 8'h00;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected tx k cycles after the start edge (tx lags the FSM state by one)
  function automatic logic exp_tx(input int k);
    int b;
    int r;
    logic [7:0] by;
    if (k < 1) return 1'b1;
    b = (k - 1) / int'(BYTE_CYC);
    r = (k - 1) % int'(BYTE_CYC);
    if (b >= int'(FL)) return 1'b1;
    if (r == 0) return 1'b1;
    if (r <= int'(CPB)) return 1'b0;
    if (r <= int'(9 * CPB)) begin
      by = ref_bytes[b];
      return by[(r - 1 - int'(CPB)) / int'(CPB)];
    end
    return 1'b1;
  endfunction

  function automatic logic [7:0] exp_idx(input int k);
    if (k >= int'(FL * BYTE_CYC)) return 8'd0;
    return 8'(k / int'(BYTE_CYC));
  endfunction

  task automatic restore_bank();
    for (int i = 0; i < int'(FL); i++) bank[i] = ref_bytes[i];
  endtask

  // Caller has start=1 before the next edge (edge E). mode 0: pulse,
  // 1: start held high, 2: start toggling. chain leaves start=1 in the
  // frame_done cycle; mangle corrupts bank entries outside their LOAD cycle.
  task automatic frame_check(input string tag, input int mode, input bit chain, input bit mangle);
    @(posedge clk); #1;
    if (mode == 0) start = 1'b0;
    check($sformatf("%s busy k=0", tag), 8'(busy), 8'd1);
    check($sformatf("%s idx k=0", tag), 8'(rd_idx), 8'd0);
    check($sformatf("%s tx k=0", tag), 8'(tx), 8'd1);
    for (int k = 1; k <= int'(FRAME_CYC); k++) begin
      @(posedge clk); #1;
      check($sformatf("%s tx k=%0d", tag, k), 8'(tx), 8'(exp_tx(k)));
      check($sformatf("%s busy k=%0d", tag, k), 8'(busy), 8'(k < int'(FRAME_CYC)));
      check($sformatf("%s done k=%0d", tag, k), 8'(frame_done), 8'(k == int'(FRAME_CYC)));
      check($sformatf("%s idx k=%0d", tag, k), 8'(rd_idx), exp_idx(k));
      if (mode == 1) start = 1'b1;
      if (mode == 2) start = k[0];
      if (mangle && k == 10)  bank[0] = 8'h00;
      if (mangle && k == 50)  bank[1] = 8'h00;
      if (mangle && k == 100) bank[2] = 8'h00;
      if (k == int'(FRAME_CYC)) begin
        restore_bank();
        start = chain;
      end
    end
  endtask

  initial begin
    ref_bytes[0] = 8'hA5;
    ref_bytes[1] = 8'h3C;
    ref_bytes[2] = 8'hFF;
    restore_bank();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset tx", 8'(tx), 8'd1);
    check("reset busy", 8'(busy), 8'd0);
    check("reset done", 8'(frame_done), 8'd0);
    check("reset idx", 8'(rd_idx), 8'd0);
    reset = 1'b0;

    // Idle with no start
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle tx c=%0d", i), 8'(tx), 8'd1);
      check($sformatf("idle busy c=%0d", i), 8'(busy), 8'd0);
      check($sformatf("idle done c=%0d", i), 8'(frame_done), 8'd0);
      check($sformatf("idle idx c=%0d", i), 8'(rd_idx), 8'd0);
    end

    // Single frame, bank modified outside LOAD cycles
    start = 1'b1;
    frame_check("single", 0, 1'b0, 1'b1);
    repeat (5) begin @(posedge clk); #1; end

    // start held high during the whole frame
    start = 1'b1;
    frame_check("held", 1, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end

    // start toggling while busy, then a start in the frame_done cycle
    start = 1'b1;
    frame_check("toggle", 2, 1'b1, 1'b0);
    frame_check("chain", 0, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end

    // Reset in the middle of byte 1 data (bit 0 of 0x3C is low at k=48)
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 48; i++) begin @(posedge clk); #1; end
    check("pre_reset tx", 8'(tx), 8'd0);
    check("pre_reset idx", 8'(rd_idx), 8'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_reset tx", 8'(tx), 8'd1);
    check("mid_reset busy", 8'(busy), 8'd0);
    check("mid_reset idx", 8'(rd_idx), 8'd0);
    check("mid_reset done", 8'(frame_done), 8'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("post_reset tx", 8'(tx), 8'd1);
      check("post_reset busy", 8'(busy), 8'd0);
    end
    start = 1'b1;
    frame_check("after_reset", 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
